button_debounce_array: RTL and testbench

BUTTON_DEBOUNCE_ARRAY -- requirements
Module: button_debounce_array

---
 rtl/button_debounce_array.sv | 140 ++++++++++++++
 tb/tb_button_debounce_array.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/button_debounce_array.sv
// Per-channel button debouncer with a two-flop (or deeper) synchroniser and a 4-state qualify FSM.
// Level, press and release outputs are registered and each channel is fully independent.
module button_debounce_array #(
  parameter int N_CH          = 4,
  parameter int STABLE_CYCLES = 1000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic [N_CH-1:0] d_input,
  output logic [N_CH-1:0] out_level,
  output logic [N_CH-1:0] out_press,
  output logic [N_CH-1:0] out_release,
  output logic            out_any_press
);

  typedef enum logic [1:0] {
    STABLE_LOW,
    WAIT_HIGH,
    STABLE_HIGH,
    WAIT_LOW
  } state_e;

  localparam int CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [N_CH-1:0] press_vec_d;
  logic            any_press_q;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    state_e                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;
    logic                   release_q, release_d;

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_input[ch]};
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        state_q   <= STABLE_LOW;
        cnt_q     <= '0;
        level_q   <= 1'b0;
        press_q   <= 1'b0;
        release_q <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        level_q   <= level_d;
        press_q   <= press_d;
        release_q <= release_d;
      end
    end

    // Counter starts at 1 on the first differing sample and never exceeds CNT_MAX.
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
        STABLE_LOW: begin
          if (s) begin
            state_d = WAIT_HIGH;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        WAIT_HIGH: begin
          if (!s) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        STABLE_HIGH: begin
          if (!s) begin
            state_d = WAIT_LOW;
            cnt_d   = CNT_ONE;
          end else begin
            cnt_d   = '0;
          end
        end
        WAIT_LOW: begin
          if (s) begin
            state_d = STABLE_HIGH;
            cnt_d   = '0;
          end else if (cnt_q == CNT_MAX) begin
            state_d = STABLE_LOW;
            cnt_d   = '0;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = STABLE_LOW;
          cnt_d   = '0;
        end
      endcase
    end

    // The level only moves on the accepting edge, so WAIT states never disturb it.
    always_comb begin
      level_d   = level_q;
      press_d   = 1'b0;
      release_d = 1'b0;
      if (state_q == WAIT_HIGH && s && cnt_q == CNT_MAX) begin
        level_d = 1'b1;
        press_d = 1'b1;
      end else if (state_q == WAIT_LOW && !s && cnt_q == CNT_MAX) begin
        level_d   = 1'b0;
        release_d = 1'b1;
      end
    end

    assign press_vec_d[ch] = press_d;
    assign out_level[ch]   = level_q;
    assign out_press[ch]   = press_q;
    assign out_release[ch] = release_q;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) any_press_q <= 1'b0;
    else       any_press_q <= |press_vec_d;
  end

  assign out_any_press = any_press_q;

endmodule

// File: tb/tb_button_debounce_array.sv
// Bench for button_debounce_array: directed scenarios then random toggling, checked against
// a run-length model of the debounce rule on a delayed copy of the raw inputs.
module tb_button_debounce_array;
  localparam int NCH    = 4;
  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [NCH-1:0] d_input;
  logic [NCH-1:0] out_level, out_press, out_release;
  logic           out_any_press;

  int total = 0;
  int bad   = 0;

  logic [NCH-1:0] histQ[$];
  int             runLen[NCH];
  logic [NCH-1:0] modelLevel, modelPress, modelRelease;

  button_debounce_array #(
    .N_CH(NCH), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .d_input(d_input),
    .out_level(out_level), .out_press(out_press), .out_release(out_release),
    .out_any_press(out_any_press)
  );

  always #5 i_clk = ~i_clk;

  task automatic modelReset();
    histQ.delete();
    for (int c = 0; c < NCH; c++) runLen[c] = 0;
    modelLevel   = '0;
    modelPress   = '0;
    modelRelease = '0;
  endtask

  // A channel flips once the value it sees SYNC edges late has differed from its level
  // for STABLE+1 consecutive edges.
  task automatic modelEdge(input logic [NCH-1:0] d);
    logic [NCH-1:0] sVal;
    histQ.push_front(d);
    if (histQ.size() > SYNC + 1) void'(histQ.pop_back());
    sVal = (histQ.size() > SYNC) ? histQ[SYNC] : '0;
    modelPress   = '0;
    modelRelease = '0;
    for (int c = 0; c < NCH; c++) begin
      if (sVal[c] != modelLevel[c]) begin
        runLen[c]++;
        if (runLen[c] == STABLE + 1) begin
          modelLevel[c] = sVal[c];
          if (sVal[c]) modelPress[c] = 1'b1;
          else         modelRelease[c] = 1'b1;
          runLen[c] = 0;
        end
      end else begin
        runLen[c] = 0;
      end
    end
  endtask

  task automatic checkOutput(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic checkAll(input string tag);
    checkOutput({tag, ".level"},   out_level,   modelLevel);
    checkOutput({tag, ".press"},   out_press,   modelPress);
    checkOutput({tag, ".release"}, out_release, modelRelease);
    checkOutput({tag, ".any"}, {3'b000, out_any_press}, {3'b000, |modelPress});
  endtask

  task automatic applyStimulus(input logic [NCH-1:0] d, input string tag);
    d_input = d;
    @(posedge i_clk);
    modelEdge(d);
    #1;
    checkAll(tag);
  endtask

  initial begin
    logic [NCH-1:0] rnd;
    i_rst   = 1'b1;
    d_input = '0;
    modelReset();
    repeat (3) @(posedge i_clk);
    #1;
    checkAll("reset");
    #2 i_rst = 1'b0;

    // Clean press on ch0: pulse exactly 6 edges after capture.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b0001, "cleanPress");
      checkOutput("cleanPress.edge6", out_press, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // Bounce on ch1, final rise captured at k=4.
    for (int k = 0; k < 14; k++) begin
      logic ch1;
      ch1 = (k < 4) ? (k % 2 == 0) : 1'b1;
      applyStimulus({2'b00, ch1, 1'b1}, "bounce");
      checkOutput("bounce.press1", {3'b000, out_press[1]}, {3'b000, (k == 10)});
    end

    // Three-cycle glitch on ch2 never qualifies.
    for (int k = 0; k < 11; k++) begin
      applyStimulus({1'b0, (k < 3), 2'b11}, "glitch");
      checkOutput("glitch.level2", {3'b000, out_level[2]}, 4'b0000);
    end

    // Release of ch0.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b0010, "release");
      checkOutput("release.edge6", out_release, (k == 6) ? 4'b0001 : 4'b0000);
    end

    // ch0 and ch3 rise together.
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b1011, "concurrent");
      checkOutput("concurrent.edge6", out_press, (k == 6) ? 4'b1001 : 4'b0000);
    end

    for (int k = 0; k < 10; k++) applyStimulus(4'b1000, "settle");

    // ch1 mid-qualification when reset pulses between edges; ch3 level is high beforehand.
    for (int k = 0; k < 3; k++) applyStimulus(4'b1010, "preReset");
    #2 i_rst = 1'b1;
    #1;
    modelReset();
    checkAll("asyncReset");
    checkOutput("asyncReset.levelZero", out_level, 4'b0000);
    #1 i_rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      applyStimulus(4'b1010, "postReset");
      checkOutput("postReset.edge6", out_press, (k == 6) ? 4'b1010 : 4'b0000);
    end

    // Random toggling with occasional long holds so both accepts and rejects occur.
    rnd = 4'b1010;
    for (int k = 0; k < 600; k++) begin
      for (int c = 0; c < NCH; c++)
        if ($urandom_range(0, 7) == 0) rnd[c] = ~rnd[c];
      applyStimulus(rnd, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
